// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   pipe_state_t     : sequencer state encoding (RUN/MULTI/HALT)
//   MULTI_CYCLES_DEF : default EX occupancy of a mul/div instruction
//   CNT_W_DEF        : default width of the optional performance counters
//   MCNT_W           : width of the multicycle down-counter
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MULTI = 2'b01,
        HALT  = 2'b10
    } pipe_state_t;

    localparam int unsigned MULTI_CYCLES_DEF = 8;
    localparam int unsigned CNT_W_DEF        = 16;
    localparam int unsigned MCNT_W           = 8;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by
// the asynchronous active-low reset.
// Ports:
//   clk   in  clock
//   rst_n in  async active-low clear
//   inc   in  increment request
//   count out current value [W-1:0]
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Combines load-use
// hazard, EX branch resolution, EX multicycle (mul/div) and ID halt opcode
// into pipeline-register enables/flushes. Holds the pipeline for fixed-
// latency multicycle ops and parks it on halt until resume.
// Optional feature macro: PIPE_STALL_CNT_EN adds stall_count/flush_count.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load_use_hazard   load-use halt from hazard_detect
//   branch_taken_ex   branch/jump in EX resolved taken
//   multi_start_ex    EX holds a mul/div instruction
//   halt_instr_id     ID holds the halt opcode
//   resume            restart request (HALT only)
//   pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
//   ex_mem_flush      pipeline-register controls
//   multi_busy        multicycle stall in progress
//   halted            pipeline parked
//   stall_count, flush_count (macro only) saturating perf counters
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULTI_CYCLES = MULTI_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_use_hazard,
    input  logic branch_taken_ex,
    input  logic multi_start_ex,
    input  logic halt_instr_id,
    input  logic resume,
    output logic pc_enable,
    output logic if_id_enable,
    output logic if_id_flush,
    output logic id_ex_enable,
    output logic id_ex_flush,
    output logic ex_mem_flush,
    output logic multi_busy,
    output logic halted
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    if ((MULTI_CYCLES < 2) || (MULTI_CYCLES > 255) || (CNT_W < 1)) begin : g_param_check
        $error("pipeline_ctrl: MULTI_CYCLES must be 2..255 and CNT_W >= 1");
    end

    // First MULTI cycle already follows one stall cycle (the start cycle),
    // so the counter covers the remaining MULTI_CYCLES-2 stalls.
    localparam logic [MCNT_W-1:0] CNT_LOAD = MCNT_W'(MULTI_CYCLES - 2);

    pipe_state_t       r_state, w_state_next;
    logic [MCNT_W-1:0] r_cnt, w_cnt_next;
    logic              w_branch_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        pc_enable      = 1'b1;
        if_id_enable   = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_enable   = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        multi_busy     = 1'b0;
        halted         = 1'b0;
        w_branch_flush = 1'b0;
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;

        unique case (r_state)
            RUN: begin
                if (branch_taken_ex) begin
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    w_branch_flush = 1'b1;
                end else if (multi_start_ex) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_enable = 1'b0;
                    ex_mem_flush = 1'b1;
                    multi_busy   = 1'b1;
                    w_state_next = MULTI;
                    w_cnt_next   = CNT_LOAD;
                end else if (load_use_hazard) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_flush  = 1'b1;
                end else if (halt_instr_id) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    w_state_next = HALT;
                end
            end
            MULTI: begin
                if (r_cnt != '0) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_enable = 1'b0;
                    ex_mem_flush = 1'b1;
                    multi_busy   = 1'b1;
                    w_cnt_next   = r_cnt - 1'b1;
                end else begin
                    w_state_next = RUN;
                end
            end
            HALT: begin
                halted       = 1'b1;
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_flush  = 1'b1;
                if (resume) begin
                    pc_enable    = 1'b1;
                    if_id_flush  = 1'b1;
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

`ifdef PIPE_STALL_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_enable),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch_flush),
        .count (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int unsigned MC = 8;
    localparam int unsigned CW = 4;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, busy, halted}
    localparam logic [7:0] E_DEF    = 8'b1101_0000;
    localparam logic [7:0] E_MULTI  = 8'b0000_0110;
    localparam logic [7:0] E_LU     = 8'b0001_1000;
    localparam logic [7:0] E_BR     = 8'b1111_1000;
    localparam logic [7:0] E_HID    = 8'b0001_0000;
    localparam logic [7:0] E_HALTED = 8'b0001_1001;
    localparam logic [7:0] E_RESUME = 8'b1011_1001;

    logic clk = 1'b0;
    logic rst_n, load_use_hazard, branch_taken_ex, multi_start_ex, halt_instr_id, resume;
    logic pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush;
    logic ex_mem_flush, multi_busy, halted;
`ifdef PIPE_STALL_CNT_EN
    logic [CW-1:0] stall_count, flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MULTI_CYCLES(MC), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_use_hazard (load_use_hazard),
        .branch_taken_ex (branch_taken_ex),
        .multi_start_ex  (multi_start_ex),
        .halt_instr_id   (halt_instr_id),
        .resume          (resume),
        .pc_enable       (pc_enable),
        .if_id_enable    (if_id_enable),
        .if_id_flush     (if_id_flush),
        .id_ex_enable    (id_ex_enable),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .multi_busy      (multi_busy),
        .halted          (halted)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    wire [7:0] obs = {pc_enable, if_id_enable, if_id_flush, id_ex_enable,
                      id_ex_flush, ex_mem_flush, multi_busy, halted};

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic lu, input logic br, input logic ms,
                          input logic hi, input logic rs);
        load_use_hazard = lu;
        branch_taken_ex = br;
        multi_start_ex  = ms;
        halt_instr_id   = hi;
        resume          = rs;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        chk("reset_outputs", 16'(obs), 16'(E_DEF));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_reset", 16'(obs), 16'(E_DEF));

        // Load-use: one bubble cycle only
        set_in(1, 0, 0, 0, 0);
        chk("load_use", 16'(obs), 16'(E_LU));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("load_use_gone", 16'(obs), 16'(E_DEF));

        // Branch beats load-use
        set_in(1, 1, 0, 0, 0);
        chk("branch_hazard", 16'(obs), 16'(E_BR));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("branch_gone", 16'(obs), 16'(E_DEF));

        // Multicycle: stall cycles 0..6, release 7, fresh start in 8
        set_in(0, 0, 1, 0, 0);
        chk("multi_start", 16'(obs), 16'(E_MULTI));
        for (int i = 1; i < 7; i++) begin
            tick();
            set_in(1, 1, 1, 1, 0);
            chk($sformatf("multi_stall_%0d", i), 16'(obs), 16'(E_MULTI));
        end
        tick();
        set_in(1, 1, 1, 1, 1);
        chk("multi_release", 16'(obs), 16'(E_DEF));
        tick();
        set_in(0, 0, 1, 0, 0);
        chk("multi2_start", 16'(obs), 16'(E_MULTI));
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("multi2_stall_%0d", i), 16'(obs), 16'(E_MULTI));
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("multi2_release", 16'(obs), 16'(E_DEF));
        tick();
        chk("multi2_after", 16'(obs), 16'(E_DEF));

        // Priority: branch over multi, multi over load-use
        set_in(0, 1, 1, 0, 0);
        chk("prio_branch_multi", 16'(obs), 16'(E_BR));
        tick();
        set_in(1, 0, 1, 1, 0);
        chk("prio_multi_lu", 16'(obs), 16'(E_MULTI));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("prio_multi_entered", 16'(obs), 16'(E_MULTI));

        // Reset two cycles into MULTI
        tick();
        rst_n = 1'b0;
        #1;
        chk("reset_mid_multi", 16'(obs), 16'(E_DEF));
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_mid_multi_after", 16'(obs), 16'(E_DEF));

        // Load-use beats halt
        set_in(1, 0, 0, 1, 0);
        chk("prio_lu_halt", 16'(obs), 16'(E_LU));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("prio_lu_halt_next", 16'(obs), 16'(E_DEF));

        // Halt / resume
        set_in(0, 0, 0, 1, 0);
        chk("halt_id", 16'(obs), 16'(E_HID));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("halted", 16'(obs), 16'(E_HALTED));
        tick();
        set_in(1, 1, 1, 0, 0);
        chk("halted_ignores", 16'(obs), 16'(E_HALTED));
        tick();
        set_in(0, 0, 0, 0, 1);
        chk("resume", 16'(obs), 16'(E_RESUME));
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("after_resume", 16'(obs), 16'(E_DEF));

        // Reset while halted
        set_in(0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        chk("halted_again", 16'(obs), 16'(E_HALTED));
        rst_n = 1'b0;
        #1;
        chk("reset_mid_halt", 16'(obs), 16'(E_DEF));
        tick();
        rst_n = 1'b1;
        tick();

`ifdef PIPE_STALL_CNT_EN
        chk("stall_cnt_reset", 16'(stall_count), 16'h0);
        set_in(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        set_in(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        set_in(0, 0, 0, 0, 0);
        chk("stall_cnt_sat", 16'(stall_count), 16'hF);
        chk("flush_cnt", 16'(flush_count), 16'h3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
